// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Upper nibble of the optional per-packet header byte; lower nibble is the requester index.
    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HDR  = ST_HDR,
        DATA = ST_DATA
    } arb_state_t;

    // Ceiling log2, never less than 1 so a degenerate width still yields a legal vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // Scan ptr+1, ptr+2, ... and keep the first requester seen.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                pick[cand]  = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding N_REQ byte streams into one UART tx port.
// Latency: one arbitration cycle before a granted packet's first byte, then pure passthrough.
// Backpressure: i_ready goes straight to the granted requester; others see o_ready=0. Optional header via UART_ARB_HDR_EN.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ*8-1:0] i_data,
    input  logic [N_REQ-1:0]   i_valid,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_ready,
    output logic [7:0]         o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int               PTR_W  = clog2(N_REQ);
    localparam int               WD_W   = clog2(TIMEOUT_CYC + 1);
    localparam bit               WD_EN  = (TIMEOUT_CYC > 0);
    localparam logic [WD_W-1:0]  WD_LIM = WD_W'(TIMEOUT_CYC);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic [7:0]       g_data;
    logic             g_valid;
    logic             g_last;
    logic             hs;
    logic             wd_hit;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req  (i_valid),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    // Select the granted requester's byte lane.
    always_comb begin
        g_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(gidx_q) == k) begin
                g_data = i_data[k*8 +: 8];
            end
        end
    end

    assign g_valid = i_valid[gidx_q];
    assign g_last  = i_last[gidx_q];
    assign hs      = g_valid & i_ready;
    assign wd_hit  = WD_EN && (wd_q == WD_LIM);

`ifdef UART_ARB_HDR_EN
    logic [3:0] hdr_idx;
    assign hdr_idx = 4'(gidx_q);
`endif

    // Next-state, grant, watchdog and output muxing; reset blanks outputs so no byte moves that cycle.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        o_valid   = 1'b0;
        o_ready   = '0;
        o_data    = '0;
        o_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (|i_valid) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
`ifdef UART_ARB_HDR_EN
                    state_d = HDR;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            HDR: begin
                o_valid = 1'b1;
                o_data  = {HDR_TAG, hdr_idx};
                if (i_ready) begin
                    state_d = DATA;
                end
            end
`endif
            DATA: begin
                o_data  = g_data;
                o_valid = g_valid;
                o_ready = grant_q & {N_REQ{i_ready}};
                if (hs) begin
                    // A handshake always beats a simultaneous watchdog expiry.
                    wd_d = '0;
                    if (g_last) begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (wd_hit) begin
                    o_timeout = 1'b1;
                    ptr_d     = gidx_q;
                    grant_d   = '0;
                    wd_d      = '0;
                    state_d   = IDLE;
                end else if (WD_EN && !g_valid) begin
                    // Only a silent requester counts; uart backpressure never does.
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (!i_rst) begin
            o_valid   = 1'b0;
            o_ready   = '0;
            o_data    = '0;
            o_timeout = 1'b0;
        end
    end

    // State registers; pointer resets to the last index so requester 0 wins first.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    assign o_grant = grant_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb in its default (headerless) build, N_REQ=4, TIMEOUT_CYC=16.
// Latency: checks are taken 1-2 time units after each rising edge.
// Backpressure: exercised via i_ready held low for 100 cycles mid-packet.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dat;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [3:0]  o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        rdy;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic        o_timeout;

    int total = 0;
    int bad   = 0;

    uart_tx_arb #(
        .N_REQ       (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (dat),
        .i_valid   (vld),
        .i_last    (lst),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (rdy),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        dat = 32'h4433_2211;
        vld = 4'hF;
        lst = 4'hF;
        rdy = 1'b1;

        // Reset held with every requester valid.
        tick();
        tick();
        chk("rst_valid",   32'(o_valid),   0);
        chk("rst_ready",   32'(o_ready),   0);
        chk("rst_grant",   32'(o_grant),   0);
        chk("rst_busy",    32'(o_busy),    0);
        chk("rst_timeout", 32'(o_timeout), 0);

        // Release: arbitration cycle moves no byte.
        rst = 1'b1;
        #1;
        chk("arb_cycle_valid", 32'(o_valid), 0);
        chk("arb_cycle_ready", 32'(o_ready), 0);

        // Round robin over single-byte packets: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_grant%0d", k), 32'(o_grant), 1 << (k % 4));
            chk($sformatf("rr_data%0d", k),  32'(o_data),  8'h11 * ((k % 4) + 1));
            chk($sformatf("rr_ready%0d", k), 32'(o_ready), 1 << (k % 4));
            chk($sformatf("rr_valid%0d", k), 32'(o_valid), 1);
            tick();
            chk($sformatf("rr_gap_grant%0d", k), 32'(o_grant), 0);
            chk($sformatf("rr_gap_busy%0d", k),  32'(o_busy),  0);
        end
        vld = 4'h0;
        lst = 4'h0;

        // Packet lock: req0 sends 11,22,33 while req2 waits.
        dat[7:0] = 8'h11;
        vld = 4'b0001;
        tick();
        vld = 4'b0101;
        dat[23:16] = 8'hC2;
        lst = 4'b0100;
        #1;
        chk("lock_grant",   32'(o_grant), 32'h1);
        chk("lock_b0",      32'(o_data),  32'h11);
        chk("lock_ready",   32'(o_ready), 32'h1);
        tick();
        dat[7:0] = 8'h22;
        #1;
        chk("lock_b1",      32'(o_data),  32'h22);
        chk("lock_grant1",  32'(o_grant), 32'h1);
        tick();
        dat[7:0] = 8'h33;
        lst = 4'b0101;
        #1;
        chk("lock_b2",      32'(o_data),  32'h33);
        chk("lock_valid2",  32'(o_valid), 1);
        tick();
        chk("lock_end_grant", 32'(o_grant), 0);
        chk("lock_end_valid", 32'(o_valid), 0);
        vld = 4'b0100;
        tick();
        chk("lock_next_grant", 32'(o_grant), 32'h4);
        chk("lock_next_data",  32'(o_data),  32'hC2);
        tick();
        vld = 4'h0;
        lst = 4'h0;
        chk("lock_next_done", 32'(o_busy), 0);

        // Backpressure: i_ready low 100 cycles mid-packet, watchdog must stay quiet.
        dat[15:8] = 8'h5A;
        vld = 4'b0010;
        tick();
        chk("bp_grant", 32'(o_grant), 32'h2);
        rdy = 1'b0;
        #1;
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("bp_timeout%0d", i), 32'(o_timeout), 0);
            chk($sformatf("bp_data%0d", i),    32'(o_data),    32'h5A);
            chk($sformatf("bp_ready%0d", i),   32'(o_ready),   0);
            tick();
        end
        chk("bp_still_granted", 32'(o_grant), 32'h2);
        rdy = 1'b1;
        #1;
        chk("bp_release_ready", 32'(o_ready), 32'h2);
        tick();

        // Watchdog: req1 silent after byte 1 -> pulse after 16 idle DATA cycles.
        vld = 4'h0;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wd_quiet%0d", i), 32'(o_timeout), 0);
            tick();
        end
        chk("wd_pulse",       32'(o_timeout), 1);
        chk("wd_pulse_grant", 32'(o_grant),   32'h2);
        tick();
        chk("wd_after_grant",   32'(o_grant),   0);
        chk("wd_after_busy",    32'(o_busy),    0);
        chk("wd_after_timeout", 32'(o_timeout), 0);

        // Expiry coinciding with a handshake: handshake wins.
        dat[15:8] = 8'hA1;
        vld = 4'b0010;
        tick();
        chk("tie_grant", 32'(o_grant), 32'h2);
        chk("tie_b0",    32'(o_data),  32'hA1);
        tick();
        vld = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        dat[15:8] = 8'hA2;
        vld = 4'b0010;
        lst = 4'b0010;
        #1;
        chk("tie_no_timeout", 32'(o_timeout), 0);
        chk("tie_ready",      32'(o_ready),   32'h2);
        chk("tie_data",       32'(o_data),    32'hA2);
        tick();
        chk("tie_end_grant",   32'(o_grant),   0);
        chk("tie_end_timeout", 32'(o_timeout), 0);
        vld = 4'h0;
        lst = 4'h0;

        // Reset mid-packet abandons it and restores pointer so req0 wins.
        dat[31:24] = 8'h77;
        vld = 4'b1000;
        lst = 4'b1000;
        tick();
        chk("mid_grant", 32'(o_grant), 32'h8);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_ready", 32'(o_ready), 0);
        tick();
        chk("mid_rst_grant", 32'(o_grant), 0);
        chk("mid_rst_busy",  32'(o_busy),  0);
        rst = 1'b1;
        dat[7:0] = 8'h99;
        vld = 4'b1001;
        lst = 4'b1001;
        tick();
        chk("post_rst_grant", 32'(o_grant), 32'h1);
        chk("post_rst_data",  32'(o_data),  32'h99);
        tick();
        vld = 4'h0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
